rca_pipe: RTL and testbench

RCA_PIPE -- requirements
Module: rca_pipe

---
 rtl/rca_pipe.sv | 121 ++++++++++++
 tb/tb_rca_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe.sv
// rtl/rca_pipe.sv - pipelined ripple-carry adder, one SW-bit slice per stage; RCA_PIPE_OVF_EN adds signed-overflow output ov
module rca_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
`ifdef RCA_PIPE_OVF_EN
    output logic             ov,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SW = WIDTH / STAGES;

    // Index k of these arrays is what enters stage k; index 0 is the input port side.
    logic [WIDTH-1:0] op_a  [STAGES];
    logic [WIDTH-1:0] op_b  [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES+1];
    logic [STAGES:0]  cy_q;
    logic [STAGES:0]  vld;
    logic [STAGES:0]  rdy;

    assign op_a[0]  = a;
    assign op_b[0]  = b;
    assign sum_q[0] = '0;
    assign cy_q[0]  = ci;
    assign vld[0]   = in_valid;

    // Ready ripples back from the output: a stage can load if empty or if its content moves on.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld[k+1] || rdy[k+1];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES];
    assign s         = sum_q[STAGES];
    assign co        = cy_q[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW:0]      add;
        logic [WIDTH-1:0] sum_n;
        logic [WIDTH-1:0] sum_r;
        logic             cy_r;
        logic             v_r;

        // Add this stage's operand slice with the carry handed over by the previous stage.
        always_comb begin
            add   = {1'b0, op_a[k][k*SW +: SW]} + {1'b0, op_b[k][k*SW +: SW]}
                  + {{SW{1'b0}}, cy_q[k]};
            sum_n = sum_q[k];
            sum_n[k*SW +: SW] = add[SW-1:0];
        end

        // Stage register: loads only when ready, otherwise holds data and valid.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_r   <= 1'b0;
                sum_r <= '0;
                cy_r  <= 1'b0;
            end else if (rdy[k]) begin
                v_r   <= vld[k];
                sum_r <= sum_n;
                cy_r  <= add[SW];
            end
        end

        assign sum_q[k+1] = sum_r;
        assign cy_q[k+1]  = cy_r;
        assign vld[k+1]   = v_r;

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;

            // Operands travel alongside the partial sum so later slices can still be added.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (rdy[k]) begin
                    a_r <= op_a[k];
                    b_r <= op_b[k];
                end
            end

            assign op_a[k+1] = a_r;
            assign op_b[k+1] = b_r;
        end

`ifdef RCA_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ov_r;

            // Carry into the MSB is a^b^s at that bit; overflow is it XOR the final carry.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ov_r <= 1'b0;
                end else if (rdy[k]) begin
                    ov_r <= op_a[k][WIDTH-1] ^ op_b[k][WIDTH-1] ^ add[SW-1] ^ add[SW];
                end
            end

            assign ov = ov_r;
        end
`endif
    end

endmodule

// File: tb/tb_rca_pipe.sv
// tb/tb_rca_pipe.sv - self-checking bench for rca_pipe (WIDTH=16, STAGES=4)
module tb_rca_pipe;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] s;
    logic        co;
    logic        out_valid;
    logic        out_ready;
`ifdef RCA_PIPE_OVF_EN
    logic        ov;
`endif

    rca_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .ci       (ci),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s        (s),
        .co       (co),
`ifdef RCA_PIPE_OVF_EN
        .ov       (ov),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          t;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_stall = -1;
    int          n_acc = 0;
    int          n_deliv = 0;
    logic        hold_pending = 1'b0;
    logic [15:0] hold_s;
    logic        hold_co;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, score the handshakes the next rising edge performs.
    task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic ordy, input logic irst);
        exp_t        e;
        logic [16:0] full;
        rst = irst; in_valid = iv; a = ia; b = ib; ci = ic; out_ready = ordy;
        #1;
        if (hold_pending) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_s", {16'd0, s}, {16'd0, hold_s});
            check("hold_co", {31'd0, co}, {31'd0, hold_co});
        end
        if (!irst && out_valid && out_ready) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum", {16'd0, s}, {16'd0, e.s});
                check("carry", {31'd0, co}, {31'd0, e.co});
`ifdef RCA_PIPE_OVF_EN
                check("overflow", {31'd0, ov}, {31'd0, e.ov});
`endif
                if (e.t > last_stall) check("latency", cyc - e.t, 32'd4);
            end
        end
        if (!irst && in_valid && in_ready) begin
            n_acc++;
            full = {1'b0, ia} + {1'b0, ib} + {16'd0, ic};
            e.s  = full[15:0];
            e.co = full[16];
            e.ov = (ia[15] == ib[15]) && (full[15] != ia[15]);
            e.t  = cyc;
            exp_q.push_back(e);
        end
        hold_pending = out_valid && !out_ready && !irst;
        if (hold_pending) begin
            hold_s     = s;
            hold_co    = co;
            last_stall = cyc;
        end
        if (irst) exp_q.delete();
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    endtask

    int acc0;
    int del0;

    initial begin
        // Reset held two cycles with in_valid asserted.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b1);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_s", {16'd0, s}, 32'd0);
            check("rst_co", {31'd0, co}, 32'd0);
        end
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_nothing_queued", exp_q.size(), 32'd0);

        // All-ones plus one wraps to zero with carry out, after exactly four cycles.
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        idle(2);
        check("wrap_not_early", {31'd0, out_valid}, 32'd0);
        idle(1);
        check("wrap_valid", {31'd0, out_valid}, 32'd1);
        check("wrap_s", {16'd0, s}, 32'h0000);
        check("wrap_co", {31'd0, co}, 32'd1);
        idle(2);

`ifdef RCA_PIPE_OVF_EN
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0);
        idle(2);
        check("ovf1_s", {16'd0, s}, 32'h8000);
        check("ovf1_co", {31'd0, co}, 32'd0);
        check("ovf1_ov", {31'd0, ov}, 32'd1);
        idle(1);
        check("ovf2_s", {16'd0, s}, 32'h0000);
        check("ovf2_co", {31'd0, co}, 32'd1);
        check("ovf2_ov", {31'd0, ov}, 32'd1);
        idle(2);
`endif

        // Eight back-to-back operations.
        acc0 = n_acc; del0 = n_deliv;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'(i * 16'h1111), 16'h0F0F, i[0], 1'b1, 1'b0);
        end
        idle(4);
        check("b2b_accepted", n_acc - acc0, 32'd8);
        check("b2b_delivered", n_deliv - del0, 32'd8);

        // Backpressure: pipeline fills with four and stalls.
        acc0 = n_acc; del0 = n_deliv;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0);
        end
        check("bp_accepted", n_acc - acc0, 32'd4);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
        idle(6);
        check("bp_all_delivered", n_deliv - del0, n_acc - acc0);
        check("bp_queue_empty", exp_q.size(), 32'd0);

        // Mid-flight reset discards three operations.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
        del0 = n_deliv;
        idle(6);
        check("flush_no_output", n_deliv - del0, 32'd0);
        step(1'b1, 16'hA5A5, 16'h5A5B, 1'b1, 1'b1, 1'b0);
        idle(4);
        check("after_flush_delivered", n_deliv - del0, 32'd1);

        // Random traffic with backpressure and occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 63) == 0));
        end
        idle(8);
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
